// File: rtl/debug_pkg.sv
// Shared constants for the debug command engine: opcodes, debug source types,
// FSM state encoding and command frame field positions.
package debug_pkg;

    localparam int OP_HI     = 31;
    localparam int OP_LO     = 26;
    localparam int TOGGLE    = 25;
    localparam int TYPE_HI   = 24;
    localparam int TYPE_LO   = 16;
    localparam int DATA_HI   = 15;
    localparam int DATA_LO   = 0;

    localparam logic [5:0] OP_START         = 6'h01;
    localparam logic [5:0] OP_RESET         = 6'h02;
    localparam logic [5:0] OP_REQ_DATA      = 6'h03;
    localparam logic [5:0] OP_LOAD_LSB      = 6'h04;
    localparam logic [5:0] OP_LOAD_MSB      = 6'h05;
    localparam logic [5:0] OP_MODE_GET      = 6'h08;
    localparam logic [5:0] OP_MODE_SET_CONT = 6'h09;
    localparam logic [5:0] OP_MODE_SET_STEP = 6'h0A;
    localparam logic [5:0] OP_ACK_DATA      = 6'h0B;
    localparam logic [5:0] OP_READ_CYCLES   = 6'h0C;
    localparam logic [5:0] OP_STEP          = 6'h20;

    localparam logic [8:0] TYPE_REG    = 9'h001;
    localparam logic [8:0] TYPE_IF_ID  = 9'h002;
    localparam logic [8:0] TYPE_ID_EX  = 9'h003;
    localparam logic [8:0] TYPE_EX_MEM = 9'h004;
    localparam logic [8:0] TYPE_MEM_WB = 9'h005;
    localparam logic [8:0] TYPE_MEM    = 9'h006;
    localparam logic [8:0] TYPE_PC     = 9'h007;

    // Sliced to NB_SELECT at the point of use.
    localparam logic [31:0] SELECT_NONE = '1;

    localparam logic MODE_CONT = 1'b0;
    localparam logic MODE_STEP = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_STEPPING = 3'd2,
        ST_RST_HOLD = 3'd3,
        ST_SEND     = 3'd4,
        ST_WAIT_ACK = 3'd5
    } state_e;

endpackage

// File: rtl/debug_command_unit_if.sv
// Frame, response and MIPS-side signals of the debug command engine.
// slave = the engine, master = MicroBlaze/MIPS side.
interface debug_command_unit_if #(
    parameter int NB_FRAME      = 32,
    parameter int NB_INSTR_ADDR = 9,
    parameter int NB_SELECT     = 6
);
    logic [NB_FRAME-1:0]      i_frame_from_blaze;
    logic [NB_FRAME-1:0]      o_frame_to_blaze;
    logic                     o_rsp_toggle;
    logic                     o_rsp_eod;
    logic [NB_FRAME-1:0]      i_frame_from_mips;
    logic                     i_eod;
    logic                     i_eop;
    logic                     o_valid;
    logic                     o_reset;
    logic                     o_instr_we;
    logic [NB_INSTR_ADDR-1:0] o_instr_addr;
    logic [31:0]              o_instr_data;
    logic [NB_SELECT-1:0]     o_request_select;
    logic                     o_req_next;

    modport slave (
        input  i_frame_from_blaze, i_frame_from_mips, i_eod, i_eop,
        output o_frame_to_blaze, o_rsp_toggle, o_rsp_eod, o_valid, o_reset,
               o_instr_we, o_instr_addr, o_instr_data, o_request_select, o_req_next
    );

    modport master (
        output i_frame_from_blaze, i_frame_from_mips, i_eod, i_eop,
        input  o_frame_to_blaze, o_rsp_toggle, o_rsp_eod, o_valid, o_reset,
               o_instr_we, o_instr_addr, o_instr_data, o_request_select, o_req_next
    );
endinterface

// File: rtl/debug_select_lut.sv
// Maps a REQ_DATA type field (plus register index for REG) to a debug source select.
module debug_select_lut
    import debug_pkg::*;
#(
    parameter int NB_SELECT = 6
) (
    input  logic [8:0]           type_code,
    input  logic [4:0]           reg_index,
    output logic [NB_SELECT-1:0] select
);
    always_comb begin
        select = SELECT_NONE[NB_SELECT-1:0];
        case (type_code)
            TYPE_REG:    select = NB_SELECT'(reg_index);
            TYPE_IF_ID:  select = NB_SELECT'(6'h20);
            TYPE_ID_EX:  select = NB_SELECT'(6'h21);
            TYPE_EX_MEM: select = NB_SELECT'(6'h22);
            TYPE_MEM_WB: select = NB_SELECT'(6'h23);
            TYPE_MEM:    select = NB_SELECT'(6'h24);
            TYPE_PC:     select = NB_SELECT'(6'h25);
            default:     select = SELECT_NONE[NB_SELECT-1:0];
        endcase
    end
endmodule

// File: rtl/debug_command_unit.sv
// Toggle-qualified command engine between the MicroBlaze GPIO frame and the MIPS debug fabric.
// Optional DBG_CYCLE_COUNTER_EN adds a saturating o_valid cycle counter readable by READ_CYCLES.
//   state    | meaning
//   IDLE     | waiting for a command
//   RUN      | MIPS clocked until end of program
//   STEPPING | MIPS clocked for a fixed cycle count
//   RST_HOLD | MIPS reset asserted for RESET_CYCLES
//   SEND     | capture the selected debug word and present it
//   WAIT_ACK | response presented, waiting for ACK_DATA
module debug_command_unit
    import debug_pkg::*;
#(
    parameter int NB_FRAME      = 32,
    parameter int NB_INSTR_ADDR = 9,
    parameter int NB_SELECT     = 6,
    parameter int NB_STEP       = 16,
    parameter int RESET_CYCLES  = 4
) (
    input logic             i_clock,
    input logic             i_reset,
    debug_command_unit_if.slave bus
);
    state_e                   state_q, state_d;
    logic                     mode_q, mode_d;
    logic                     tog_q;
    logic [NB_STEP-1:0]       cnt_q, cnt_d;
    logic [15:0]              lsb_q, lsb_d;
    logic                     valid_q, valid_d;
    logic                     rst_q, rst_d;
    logic                     we_q, we_d;
    logic [NB_INSTR_ADDR-1:0] addr_q, addr_d;
    logic [31:0]              data_q, data_d;
    logic [NB_SELECT-1:0]     sel_q, sel_d;
    logic                     req_next_q, req_next_d;
    logic [NB_FRAME-1:0]      rsp_q, rsp_d;
    logic                     rsp_tog_q, rsp_tog_d;
    logic                     rsp_eod_q, rsp_eod_d;

    logic [NB_FRAME-1:0]      frame;
    logic [5:0]               opcode;
    logic [8:0]               type_f;
    logic [15:0]              data_f;
    logic                     accept;
    logic                     reset_cmd;
    logic [NB_SELECT-1:0]     lut_sel;

    assign frame     = bus.i_frame_from_blaze;
    assign opcode    = frame[OP_HI:OP_LO];
    assign type_f    = frame[TYPE_HI:TYPE_LO];
    assign data_f    = frame[DATA_HI:DATA_LO];
    assign accept    = frame[TOGGLE] != tog_q;
    assign reset_cmd = accept && (opcode == OP_RESET);

    debug_select_lut #(.NB_SELECT(NB_SELECT)) u_lut (
        .type_code (type_f),
        .reg_index (data_f[4:0]),
        .select    (lut_sel)
    );

`ifdef DBG_CYCLE_COUNTER_EN
    logic [31:0] cycles_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)                        cycles_q <= '0;
        else if (reset_cmd)                  cycles_q <= '0;
        else if (valid_q && cycles_q != '1)  cycles_q <= cycles_q + 32'd1;
    end
`endif

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        lsb_d      = lsb_q;
        valid_d    = valid_q;
        rst_d      = rst_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        sel_d      = sel_q;
        req_next_d = 1'b0;
        rsp_d      = rsp_q;
        rsp_tog_d  = rsp_tog_q;
        rsp_eod_d  = rsp_eod_q;

        // RESET overrides everything, including a simultaneous i_eop.
        if (reset_cmd) begin
            state_d = ST_RST_HOLD;
            cnt_d   = NB_STEP'(RESET_CYCLES - 1);
            rst_d   = 1'b1;
            valid_d = 1'b0;
            sel_d   = SELECT_NONE[NB_SELECT-1:0];
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    case (opcode)
                        OP_START: if (mode_q == MODE_CONT) begin
                            valid_d = 1'b1;
                            state_d = ST_RUN;
                        end
                        OP_STEP: if (mode_q == MODE_STEP) begin
                            valid_d = 1'b1;
                            cnt_d   = (data_f == '0) ? '0 : NB_STEP'(data_f) - NB_STEP'(1);
                            state_d = ST_STEPPING;
                        end
                        OP_MODE_SET_CONT: mode_d = MODE_CONT;
                        OP_MODE_SET_STEP: mode_d = MODE_STEP;
                        OP_LOAD_LSB:      lsb_d  = data_f;
                        OP_LOAD_MSB: begin
                            we_d   = 1'b1;
                            addr_d = frame[NB_INSTR_ADDR+15:16];
                            data_d = {data_f, lsb_q};
                        end
                        OP_REQ_DATA: begin
                            sel_d   = lut_sel;
                            state_d = ST_SEND;
                        end
                        OP_MODE_GET: begin
                            rsp_d     = '0;
                            rsp_d[0]  = mode_q;
                            rsp_eod_d = 1'b1;
                            rsp_tog_d = ~rsp_tog_q;
                            state_d   = ST_WAIT_ACK;
                        end
`ifdef DBG_CYCLE_COUNTER_EN
                        OP_READ_CYCLES: begin
                            rsp_d     = NB_FRAME'(cycles_q);
                            rsp_eod_d = 1'b1;
                            rsp_tog_d = ~rsp_tog_q;
                            state_d   = ST_WAIT_ACK;
                        end
`endif
                        default: ;
                    endcase
                end
                ST_RUN: if (bus.i_eop) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
                ST_STEPPING: begin
                    if (bus.i_eop || cnt_q == '0) begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - NB_STEP'(1);
                    end
                end
                ST_RST_HOLD: begin
                    if (cnt_q == '0) begin
                        rst_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - NB_STEP'(1);
                    end
                end
                ST_SEND: begin
                    rsp_d     = bus.i_frame_from_mips;
                    rsp_eod_d = bus.i_eod;
                    rsp_tog_d = ~rsp_tog_q;
                    state_d   = ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    // After o_req_next the source needs one cycle to present its next word.
                    if (req_next_q) begin
                        state_d = ST_SEND;
                    end else if (accept && opcode == OP_ACK_DATA) begin
                        if (rsp_eod_q) begin
                            sel_d   = SELECT_NONE[NB_SELECT-1:0];
                            state_d = ST_IDLE;
                        end else begin
                            req_next_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_CONT;
            tog_q      <= 1'b0;
            cnt_q      <= '0;
            lsb_q      <= '0;
            valid_q    <= 1'b0;
            rst_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            sel_q      <= SELECT_NONE[NB_SELECT-1:0];
            req_next_q <= 1'b0;
            rsp_q      <= '0;
            rsp_tog_q  <= 1'b0;
            rsp_eod_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            tog_q      <= frame[TOGGLE];
            cnt_q      <= cnt_d;
            lsb_q      <= lsb_d;
            valid_q    <= valid_d;
            rst_q      <= rst_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
            req_next_q <= req_next_d;
            rsp_q      <= rsp_d;
            rsp_tog_q  <= rsp_tog_d;
            rsp_eod_q  <= rsp_eod_d;
        end
    end

    assign bus.o_frame_to_blaze = rsp_q;
    assign bus.o_rsp_toggle     = rsp_tog_q;
    assign bus.o_rsp_eod        = rsp_eod_q;
    assign bus.o_valid          = valid_q;
    assign bus.o_reset          = rst_q;
    assign bus.o_instr_we       = we_q;
    assign bus.o_instr_addr     = addr_q;
    assign bus.o_instr_data     = data_q;
    assign bus.o_request_select = sel_q;
    assign bus.o_req_next       = req_next_q;

endmodule
